// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RISC-V control unit:
// FSM states, opcode classes, ALU op codes and datapath mux selects.
package riscv_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE, FETCH, DECODE, EXEC, MEM, WB, BRANCH, TRAP
   } state_e;

   typedef enum logic [1:0] {
      CLS_R, CLS_I, CLS_LOAD, CLS_STORE
   } op_class_e;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_SLL  = 4'b0010;
   localparam logic [3:0] ALU_SRL  = 4'b0011;
   localparam logic [3:0] ALU_SLTU = 4'b0100;

   localparam logic [1:0] SRCB_RS2  = 2'd0;
   localparam logic [1:0] SRCB_IMM  = 2'd1;
   localparam logic [1:0] SRCB_FOUR = 2'd2;

   localparam logic [1:0] IMM_I = 2'd0;
   localparam logic [1:0] IMM_S = 2'd1;
   localparam logic [1:0] IMM_B = 2'd2;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // Only meaningful for opcodes DECODE routes to EXEC.
   function automatic op_class_e classify(input logic [6:0] opcode);
      case (opcode)
         OP_I:     return CLS_I;
         OP_LOAD:  return CLS_LOAD;
         OP_STORE: return CLS_STORE;
         default:  return CLS_R;
      endcase
   endfunction

endpackage

// File: rtl/riscv_mc_control_alu_op_decode.sv
// Combinational ALU op decode for the EXEC state: maps instruction class,
// funct3 and funct7 to an ALU op and a legality flag.
module alu_op_decode
   import riscv_ctrl_pkg::*;
(
   input  op_class_e   cls,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   output logic [3:0]  alu_op,
   output logic        legal
);

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      alu_op = ALU_ADD;
      legal  = 1'b0;
      case (cls)
         CLS_R: begin
            case (funct3)
               3'b000: begin
                  if (funct7 == F7_BASE) begin
                     legal = 1'b1;
                  end else if (funct7 == F7_ALT) begin
                     alu_op = ALU_SUB;
                     legal  = 1'b1;
                  end
               end
               3'b001: begin alu_op = ALU_SLL;  legal = (funct7 == F7_BASE); end
               3'b101: begin alu_op = ALU_SRL;  legal = (funct7 == F7_BASE); end
               3'b011: begin alu_op = ALU_SLTU; legal = (funct7 == F7_BASE); end
               default: ;
            endcase
         end
         CLS_I: begin
            // funct7 is immediate data for addi/sltiu; only shifts constrain it.
            case (funct3)
               3'b000: legal = 1'b1;
               3'b001: begin alu_op = ALU_SLL;  legal = (funct7 == F7_BASE); end
               3'b101: begin alu_op = ALU_SRL;  legal = (funct7 == F7_BASE); end
               3'b011: begin alu_op = ALU_SLTU; legal = 1'b1; end
               default: ;
            endcase
         end
         CLS_LOAD, CLS_STORE: legal = (funct3 == 3'b010);
         default: ;
      endcase
   end

endmodule

// File: rtl/riscv_mc_control.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/writeback,
// drives ALU op and datapath enables, resolves branches, counts retirements.
module riscv_mc_control
   import riscv_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        zero,
   input  logic        less,
   input  logic        memReady,
   output logic [3:0]  aluOp,
   output logic        aluSrcA,
   output logic [1:0]  aluSrcB,
   output logic [1:0]  immSel,
   output logic        memRead,
   output logic        memWrite,
   output logic        irWrite,
   output logic        pcWrite,
   output logic        pcSrc,
   output logic        regWrite,
   output logic        memToReg,
   output logic        illegal,
   output logic [31:0] instrCount
);

   state_e     state, state_nxt;
   op_class_e  cls;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [3:0] dec_op;
   logic       dec_legal;
   logic       is_load;
   logic       br_legal, br_taken;
   logic       retire;
   logic       unused_fields;

   assign opcode        = instr[6:0];
   assign funct3        = instr[14:12];
   assign funct7        = instr[31:25];
   assign cls           = classify(opcode);
   assign is_load       = (cls == CLS_LOAD);
   assign unused_fields = ^{instr[24:15], instr[11:7]};

   alu_op_decode u_alu_op_decode (
      .cls    (cls),
      .funct3 (funct3),
      .funct7 (funct7),
      .alu_op (dec_op),
      .legal  (dec_legal)
   );

   // NOTE: async reset, and non-blocking assignments for all registered state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         instrCount <= '0;
      end else begin
         state <= state_nxt;
         if (retire) instrCount <= instrCount + 32'd1;
      end
   end

   always_comb begin
      br_legal = 1'b1;
      br_taken = 1'b0;
      case (funct3)
         3'b000:  br_taken = zero;
         3'b001:  br_taken = !zero;
         3'b100:  br_taken = less;
         3'b101:  br_taken = !less;
         default: br_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      aluOp     = ALU_ADD;
      aluSrcA   = 1'b0;
      aluSrcB   = SRCB_RS2;
      immSel    = IMM_I;
      memRead   = 1'b0;
      memWrite  = 1'b0;
      irWrite   = 1'b0;
      pcWrite   = 1'b0;
      pcSrc     = 1'b0;
      regWrite  = 1'b0;
      memToReg  = 1'b0;
      illegal   = 1'b0;
      retire    = 1'b0;
      unique case (state)
         IDLE: state_nxt = FETCH;
         FETCH: begin
            memRead = 1'b1;
            aluSrcA = 1'b1;
            aluSrcB = SRCB_FOUR;
            if (memReady) begin
               irWrite   = 1'b1;
               pcWrite   = 1'b1;
               state_nxt = DECODE;
            end
         end
         DECODE: begin
            case (opcode)
               OP_R, OP_I, OP_LOAD, OP_STORE: state_nxt = EXEC;
               OP_BRANCH:                     state_nxt = BRANCH;
               default:                       state_nxt = TRAP;
            endcase
         end
         EXEC: begin
            if (dec_legal) begin
               aluOp     = dec_op;
               aluSrcB   = (cls == CLS_R) ? SRCB_RS2 : SRCB_IMM;
               immSel    = (cls == CLS_STORE) ? IMM_S : IMM_I;
               state_nxt = (is_load || cls == CLS_STORE) ? MEM : WB;
            end else begin
               state_nxt = TRAP;
            end
         end
         MEM: begin
            // Address path stays driven for the whole request.
            aluSrcB  = SRCB_IMM;
            immSel   = is_load ? IMM_I : IMM_S;
            memRead  = is_load;
            memWrite = !is_load;
            if (memReady) begin
               state_nxt = is_load ? WB : FETCH;
               retire    = !is_load;
            end
         end
         WB: begin
            regWrite  = 1'b1;
            memToReg  = is_load;
            state_nxt = FETCH;
            retire    = 1'b1;
         end
         BRANCH: begin
            if (br_legal) begin
               aluOp     = ALU_SUB;
               immSel    = IMM_B;
               pcWrite   = br_taken;
               pcSrc     = br_taken;
               state_nxt = FETCH;
               retire    = 1'b1;
            end else begin
               state_nxt = TRAP;
            end
         end
         TRAP: illegal = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_riscv_mc_control.sv
// Scoreboard bench for riscv_mc_control: stimulus pushes the expected control
// bundle for each cycle, a negedge monitor pops and compares it.
module tb_riscv_mc_control;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr;
   logic        zero, less, memReady;
   logic [3:0]  aluOp;
   logic        aluSrcA;
   logic [1:0]  aluSrcB, immSel;
   logic        memRead, memWrite, irWrite, pcWrite, pcSrc, regWrite, memToReg, illegal;
   logic [31:0] instrCount;

   riscv_mc_control dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .instr      (instr),
      .zero       (zero),
      .less       (less),
      .memReady   (memReady),
      .aluOp      (aluOp),
      .aluSrcA    (aluSrcA),
      .aluSrcB    (aluSrcB),
      .immSel     (immSel),
      .memRead    (memRead),
      .memWrite   (memWrite),
      .irWrite    (irWrite),
      .pcWrite    (pcWrite),
      .pcSrc      (pcSrc),
      .regWrite   (regWrite),
      .memToReg   (memToReg),
      .illegal    (illegal),
      .instrCount (instrCount)
   );

   always #5 clk = ~clk;

   // Bundle: {aluOp, aluSrcA, aluSrcB, immSel, memRead, memWrite, irWrite,
   //          pcWrite, pcSrc, regWrite, memToReg, illegal}
   localparam logic [16:0] Z      = 17'd0;
   localparam logic [16:0] F_RDY  = {4'b0000, 1'b1, 2'd2, 2'd0, 8'b1011_0000};
   localparam logic [16:0] F_WT   = {4'b0000, 1'b1, 2'd2, 2'd0, 8'b1000_0000};
   localparam logic [16:0] EX_SUB = {4'b0001, 1'b0, 2'd0, 2'd0, 8'b0000_0000};
   localparam logic [16:0] EX_LD  = {4'b0000, 1'b0, 2'd1, 2'd0, 8'b0000_0000};
   localparam logic [16:0] EX_ST  = {4'b0000, 1'b0, 2'd1, 2'd1, 8'b0000_0000};
   localparam logic [16:0] MEM_LD = {4'b0000, 1'b0, 2'd1, 2'd0, 8'b1000_0000};
   localparam logic [16:0] MEM_ST = {4'b0000, 1'b0, 2'd1, 2'd1, 8'b0100_0000};
   localparam logic [16:0] WB_R   = {4'b0000, 1'b0, 2'd0, 2'd0, 8'b0000_0100};
   localparam logic [16:0] WB_L   = {4'b0000, 1'b0, 2'd0, 2'd0, 8'b0000_0110};
   localparam logic [16:0] BR_T   = {4'b0001, 1'b0, 2'd0, 2'd2, 8'b0001_1000};
   localparam logic [16:0] BR_N   = {4'b0001, 1'b0, 2'd0, 2'd2, 8'b0000_0000};
   localparam logic [16:0] TRAPPED = {4'b0000, 1'b0, 2'd0, 2'd0, 8'b0000_0001};

   localparam logic [31:0] I_ADD  = 32'h002081B3;
   localparam logic [31:0] I_SUB  = 32'h402081B3;
   localparam logic [31:0] I_SRAI = 32'h4010D093;
   localparam logic [31:0] I_LW   = 32'h0080A283;
   localparam logic [31:0] I_SW   = 32'h0050A223;
   localparam logic [31:0] I_BEQ  = 32'h00208463;
   localparam logic [31:0] I_BNE  = 32'h00209463;
   localparam logic [31:0] I_BLT  = 32'h0020C463;
   localparam logic [31:0] I_BGE  = 32'h0020D463;

   typedef struct {
      string       name;
      logic [16:0] ctl;
      logic [31:0] cnt;
   } exp_t;

   exp_t        sb[$];
   exp_t        cur;
   logic [16:0] got;
   logic [31:0] exp_cnt;
   int          total = 0;
   int          bad   = 0;

   assign got = {aluOp, aluSrcA, aluSrcB, immSel, memRead, memWrite, irWrite,
                 pcWrite, pcSrc, regWrite, memToReg, illegal};

   task automatic check(input string name, input logic [16:0] gc, input logic [31:0] gn,
                        input logic [16:0] ec, input logic [31:0] en);
      total++;
      if (gc !== ec || gn !== en) begin
         bad++;
         $display("FAIL %s: got ctl=%05h count=%0d, expected ctl=%05h count=%0d",
                  name, gc, gn, ec, en);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         cur = sb.pop_front();
         check(cur.name, got, instrCount, cur.ctl, cur.cnt);
      end
   end

   task automatic step(input string name, input logic [31:0] i, input logic mr,
                       input logic z, input logic l, input logic [16:0] ectl,
                       input logic ret);
      @(posedge clk);
      #1;
      instr    = i;
      memReady = mr;
      zero     = z;
      less     = l;
      sb.push_back('{name, ectl, exp_cnt});
      if (ret) exp_cnt = exp_cnt + 32'd1;
   endtask

   task automatic fetch_decode(input string name, input logic [31:0] i);
      step({name, " fetch"}, i, 1'b1, 1'b0, 1'b0, F_RDY, 1'b0);
      step({name, " decode"}, i, 1'b1, 1'b0, 1'b0, Z, 1'b0);
   endtask

   initial begin
      rst_n    = 1'b0;
      instr    = '0;
      zero     = 1'b0;
      less     = 1'b0;
      memReady = 1'b0;
      exp_cnt  = '0;
      #1 sb.push_back('{"reset", Z, 32'd0});
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      sb.push_back('{"idle", Z, 32'd0});

      fetch_decode("add", I_ADD);
      step("add exec", I_ADD, 1'b1, 1'b0, 1'b0, Z, 1'b0);
      step("add wb", I_ADD, 1'b1, 1'b0, 1'b0, WB_R, 1'b1);

      step("sub fetch wait", I_SUB, 1'b0, 1'b0, 1'b0, F_WT, 1'b0);
      fetch_decode("sub", I_SUB);
      step("sub exec", I_SUB, 1'b1, 1'b0, 1'b0, EX_SUB, 1'b0);
      step("sub wb", I_SUB, 1'b1, 1'b0, 1'b0, WB_R, 1'b1);

      fetch_decode("lw", I_LW);
      step("lw exec", I_LW, 1'b1, 1'b0, 1'b0, EX_LD, 1'b0);
      for (int k = 0; k < 3; k++) step("lw mem wait", I_LW, 1'b0, 1'b0, 1'b0, MEM_LD, 1'b0);
      step("lw mem ready", I_LW, 1'b1, 1'b0, 1'b0, MEM_LD, 1'b0);
      step("lw wb", I_LW, 1'b1, 1'b0, 1'b0, WB_L, 1'b1);

      fetch_decode("sw", I_SW);
      step("sw exec", I_SW, 1'b1, 1'b0, 1'b0, EX_ST, 1'b0);
      step("sw mem", I_SW, 1'b1, 1'b0, 1'b0, MEM_ST, 1'b1);

      fetch_decode("beq", I_BEQ);
      step("beq taken", I_BEQ, 1'b1, 1'b1, 1'b0, BR_T, 1'b1);
      fetch_decode("beq", I_BEQ);
      step("beq not taken", I_BEQ, 1'b1, 1'b0, 1'b0, BR_N, 1'b1);
      fetch_decode("blt", I_BLT);
      step("blt taken", I_BLT, 1'b1, 1'b0, 1'b1, BR_T, 1'b1);
      fetch_decode("bge", I_BGE);
      step("bge not taken", I_BGE, 1'b1, 1'b0, 1'b1, BR_N, 1'b1);
      fetch_decode("bne", I_BNE);
      step("bne taken", I_BNE, 1'b1, 1'b0, 1'b0, BR_T, 1'b1);

      fetch_decode("lw2", I_LW);
      step("lw2 exec", I_LW, 1'b1, 1'b0, 1'b0, EX_LD, 1'b0);
      step("lw2 mem wait", I_LW, 1'b0, 1'b0, 1'b0, MEM_LD, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      sb.push_back('{"async reset mid mem", Z, 32'd0});
      exp_cnt = '0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      sb.push_back('{"idle after reset", Z, 32'd0});
      step("fetch after reset", I_SRAI, 1'b1, 1'b0, 1'b0, F_RDY, 1'b0);
      step("srai decode", I_SRAI, 1'b1, 1'b0, 1'b0, Z, 1'b0);
      step("srai exec illegal", I_SRAI, 1'b1, 1'b0, 1'b0, Z, 1'b0);
      for (int k = 0; k < 20; k++)
         step("trap held", I_SRAI, (k % 2) == 0, 1'b0, 1'b0, TRAPPED, 1'b0);

      @(negedge clk);
      #1;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard drain: got %0d pending entries, expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
